// File: rtl/hsv_seq_ctrl.sv
// RGB->HSV sequencing controller: one pixel at a time, hue then saturation
// computed on a single shared restoring divider, with valid/ready on both sides.
module hsv_seq_ctrl #(
    parameter int H_UNIT = 30,
    parameter int S_MAX  = 255,
    parameter int DIV_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  din_r,
    input  logic [7:0]  din_g,
    input  logic [7:0]  din_b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  dout_h,
    output logic [7:0]  dout_s,
    output logic [7:0]  dout_v,
    output logic        busy,
    output logic [15:0] pix_cnt
);

    localparam int CW = $clog2(DIV_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_W - 1);
    localparam logic [7:0] OFF_G  = 8'(2 * H_UNIT);
    localparam logic [7:0] OFF_B  = 8'(4 * H_UNIT);
    localparam logic [7:0] H_WRAP = 8'(6 * H_UNIT);
    localparam logic [1:0] SEL_R  = 2'd0;
    localparam logic [1:0] SEL_G  = 2'd1;
    localparam logic [1:0] SEL_B  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_DIV_H = 3'd2,
        S_DIV_S = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [2*DIV_W:0] div_step(
        input logic [DIV_W:0]   rem,
        input logic [DIV_W-1:0] quo,
        input logic [DIV_W-1:0] dvs
    );
        logic [DIV_W:0] sh;
        logic [DIV_W:0] dz;
        sh = {rem[DIV_W-1:0], quo[DIV_W-1]};
        dz = {1'b0, dvs};
        if (sh >= dz) begin
            div_step = {sh - dz, quo[DIV_W-2:0], 1'b1};
        end else begin
            div_step = {sh, quo[DIV_W-2:0], 1'b0};
        end
    endfunction

    state_t          state_q, state_d;
    logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d;
    logic [7:0]      max_q, max_d, delta_q, delta_d, h_q, h_d;
    logic [1:0]      sel_q, sel_d;
    logic            neg_q, neg_d;
    logic [DIV_W:0]  rem_q, rem_d;
    logic [DIV_W-1:0] quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic [7:0]      dout_h_q, dout_h_d, dout_s_q, dout_s_d, dout_v_q, dout_v_d;
    logic [15:0]     pix_cnt_q, pix_cnt_d;

    logic [7:0]       mx_s, mn_s, delta_s, abs_s, qh_s, h_calc_s;
    logic [8:0]       num_s;
    logic [1:0]       sel_s;
    logic [2*DIV_W:0] step_s;
    logic [DIV_W:0]   step_rem_s;
    logic [DIV_W-1:0] step_quo_s;

    // Next-state, datapath and output computation.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        max_d       = max_q;
        delta_d     = delta_q;
        h_d         = h_q;
        sel_d       = sel_q;
        neg_d       = neg_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        dout_h_d    = dout_h_q;
        dout_s_d    = dout_s_q;
        dout_v_d    = dout_v_q;
        pix_cnt_d   = pix_cnt_q;

        if (r_q >= g_q && r_q >= b_q) begin
            sel_s = SEL_R;
            mx_s  = r_q;
            num_s = {1'b0, g_q} - {1'b0, b_q};
        end else if (g_q >= b_q) begin
            sel_s = SEL_G;
            mx_s  = g_q;
            num_s = {1'b0, b_q} - {1'b0, r_q};
        end else begin
            sel_s = SEL_B;
            mx_s  = b_q;
            num_s = {1'b0, r_q} - {1'b0, g_q};
        end
        if (r_q <= g_q && r_q <= b_q) begin
            mn_s = r_q;
        end else if (g_q <= b_q) begin
            mn_s = g_q;
        end else begin
            mn_s = b_q;
        end
        delta_s = mx_s - mn_s;
        abs_s   = num_s[8] ? 8'(9'd0 - num_s) : num_s[7:0];

        step_s     = div_step(rem_q, quo_q, dvs_q);
        step_rem_s = step_s[2*DIV_W:DIV_W];
        step_quo_s = step_s[DIV_W-1:0];
        qh_s       = step_quo_s[7:0];

        // Red sector wraps below zero to the top of the hue circle.
        case (sel_q)
            SEL_R: begin
                if (neg_q && qh_s != 8'd0) begin
                    h_calc_s = H_WRAP - qh_s;
                end else begin
                    h_calc_s = qh_s;
                end
            end
            SEL_G: h_calc_s = neg_q ? (OFF_G - qh_s) : (OFF_G + qh_s);
            SEL_B: h_calc_s = neg_q ? (OFF_B - qh_s) : (OFF_B + qh_s);
            default: h_calc_s = 8'd0;
        endcase

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    r_d     = din_r;
                    g_d     = din_g;
                    b_d     = din_b;
                    state_d = S_PREP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                max_d   = mx_s;
                delta_d = delta_s;
                sel_d   = sel_s;
                neg_d   = num_s[8];
                if (delta_s == 8'd0) begin
                    dout_h_d    = 8'd0;
                    dout_s_d    = 8'd0;
                    dout_v_d    = mx_s;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    rem_d   = '0;
                    quo_d   = DIV_W'(abs_s) * DIV_W'(H_UNIT);
                    dvs_d   = DIV_W'(delta_s);
                    cnt_d   = '0;
                    state_d = S_DIV_H;
                end
            end
            S_DIV_H: begin
                if (cnt_q == CNT_LAST) begin
                    h_d     = h_calc_s;
                    rem_d   = '0;
                    quo_d   = DIV_W'(delta_q) * DIV_W'(S_MAX);
                    dvs_d   = DIV_W'(max_q);
                    cnt_d   = '0;
                    state_d = S_DIV_S;
                end else begin
                    rem_d = step_rem_s;
                    quo_d = step_quo_s;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DIV_S: begin
                rem_d = step_rem_s;
                quo_d = step_quo_s;
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    dout_h_d    = h_q;
                    dout_s_d    = step_quo_s[7:0];
                    dout_v_d    = max_q;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    pix_cnt_d   = pix_cnt_q + 16'd1;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        // Abort overrides everything above; outputs keep the previous result.
        if (flush && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            pix_cnt_d   = pix_cnt_q;
            dout_h_d    = dout_h_q;
            dout_s_d    = dout_s_q;
            dout_v_d    = dout_v_q;
            rem_d       = '0;
            quo_d       = '0;
            dvs_d       = '0;
            cnt_d       = '0;
        end else begin
            pix_cnt_d = pix_cnt_d;
        end

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            r_q         <= 8'd0;
            g_q         <= 8'd0;
            b_q         <= 8'd0;
            max_q       <= 8'd0;
            delta_q     <= 8'd0;
            h_q         <= 8'd0;
            sel_q       <= 2'd0;
            neg_q       <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            dout_h_q    <= 8'd0;
            dout_s_q    <= 8'd0;
            dout_v_q    <= 8'd0;
            pix_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            max_q       <= max_d;
            delta_q     <= delta_d;
            h_q         <= h_d;
            sel_q       <= sel_d;
            neg_q       <= neg_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            dout_h_q    <= dout_h_d;
            dout_s_q    <= dout_s_d;
            dout_v_q    <= dout_v_d;
            pix_cnt_q   <= pix_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign dout_h    = dout_h_q;
    assign dout_s    = dout_s_q;
    assign dout_v    = dout_v_q;
    assign pix_cnt   = pix_cnt_q;

endmodule

// File: tb/tb_hsv_seq_ctrl.sv
// Scoreboard bench for hsv_seq_ctrl: the driver queues expected HSV results and
// latency, a negedge monitor checks every delivered result against the queue.
`timescale 1ns/1ps
module tb_hsv_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  din_r = 8'd0, din_g = 8'd0, din_b = 8'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  dout_h, dout_s, dout_v;
    logic        busy;
    logic [15:0] pix_cnt;

    typedef struct {
        int h;
        int s;
        int v;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    time  acc_t = 0;
    bit   ov_seen = 1'b0;

    hsv_seq_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .din_r(din_r), .din_g(din_g), .din_b(din_b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout_h(dout_h), .dout_s(dout_s), .dout_v(dout_v),
        .busy(busy), .pix_cnt(pix_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle index of the period after posedge n is n+1 (accept edge is edge 0).
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (!ov_seen) begin
                ov_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got out_valid with no pending pixel at %0t", $time);
                end else begin
                    chk("latency", int'((($time - acc_t) - 5) / 10 + 1), exp_q[0].lat);
                end
            end
            if (out_ready && !flush && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dout_h", int'(dout_h), e.h);
                chk("dout_s", int'(dout_s), e.s);
                chk("dout_v", int'(dout_v), e.v);
                ov_seen = 1'b0;
            end
        end else begin
            ov_seen = 1'b0;
        end
    end

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input bit push, input int h, input int s, input int v, input int lat);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end
        if (push) begin
            e.h = h; e.s = s; e.v = v; e.lat = lat;
            exp_q.push_back(e);
        end
        din_r = r; din_g = g; din_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        acc_t = $time;
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
        chk("in_ready_after_accept", int'(in_ready), 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
        chk("idle_reached", int'(in_ready), 1);
    endtask

    task automatic pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input int h, input int s, input int v, input int lat);
        send(r, g, b, 1'b1, h, s, v, lat);
        wait_idle();
        exp_cnt++;
        chk("pix_cnt", int'(pix_cnt), exp_cnt);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dout_h", int'(dout_h), 0);
        chk("rst_dout_s", int'(dout_s), 0);
        chk("rst_dout_v", int'(dout_v), 0);
        chk("rst_pix_cnt", int'(pix_cnt), 0);

        pixel(8'd255, 8'd0,   8'd0,   0,   255, 255, 34);
        pixel(8'd0,   8'd255, 8'd0,   60,  255, 255, 34);
        pixel(8'd0,   8'd0,   8'd255, 120, 255, 255, 34);
        pixel(8'd255, 8'd0,   8'd128, 165, 255, 255, 34);
        pixel(8'd100, 8'd100, 8'd100, 0,   0,   100, 2);
        pixel(8'd200, 8'd200, 8'd50,  30,  191, 200, 34);
        pixel(8'd0,   8'd128, 8'd255, 105, 255, 255, 34);
        pixel(8'd10,  8'd20,  8'd30,  105, 170, 30,  34);

        // Flush while idle must not disturb anything.
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_in_ready", int'(in_ready), 1);
        chk("idle_flush_pix_cnt", int'(pix_cnt), exp_cnt);

        // Backpressure: result must hold for 10 cycles.
        @(posedge clk); #1 out_ready = 1'b0;
        send(8'd0, 8'd255, 8'd0, 1'b1, 60, 255, 255, 34);
        for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_h", int'(dout_h), 60);
            chk("stall_s", int'(dout_s), 255);
            chk("stall_v", int'(dout_v), 255);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_pix_cnt", int'(pix_cnt), exp_cnt);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_cnt++;
        chk("release_pix_cnt", int'(pix_cnt), exp_cnt);
        chk("release_in_ready", int'(in_ready), 1);
        chk("release_out_valid", int'(out_valid), 0);

        // Flush at cycle 10 (in DIV_H): edge 10 is the 10th posedge after accept.
        send(8'd255, 8'd0, 8'd0, 1'b0, 0, 0, 0, 0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", int'(in_ready), 1);
        chk("flush_busy", int'(busy), 0);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_pix_cnt", int'(pix_cnt), exp_cnt);
        repeat (40) @(negedge clk);
        chk("flush_no_result", int'(pix_cnt), exp_cnt);

        // Flush and out_ready together in OUT: result dropped.
        @(posedge clk); #1 out_ready = 1'b0;
        send(8'd50, 8'd50, 8'd50, 1'b1, 0, 0, 50, 2);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        @(posedge clk); #1 begin flush = 1'b1; out_ready = 1'b1; end
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flushout_out_valid", int'(out_valid), 0);
        chk("flushout_pix_cnt", int'(pix_cnt), exp_cnt);
        chk("flushout_dropped_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());

        // Asynchronous reset in cycle 20, mid-period.
        send(8'd0, 8'd0, 8'd255, 1'b0, 0, 0, 0, 0);
        repeat (19) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_dout_h", int'(dout_h), 0);
        chk("arst_dout_s", int'(dout_s), 0);
        chk("arst_dout_v", int'(dout_v), 0);
        chk("arst_pix_cnt", int'(pix_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        pixel(8'd255, 8'd0, 8'd128, 165, 255, 255, 34);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
